// File: rtl/rd_port_arbiter_if.sv
// rtl/rd_port_arbiter_if.sv - read-port arbiter bus: two cache requesters plus AXI read bridge
interface rd_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
) ();
   // port 0 (ICache) request/return
   logic              i_rd_req;
   logic [1:0]        i_rd_type;
   logic [ADDR_W-1:0] i_rd_addr;
   logic              i_rd_rdy;
   logic              i_ret_valid;
   logic              i_ret_half;
   // port 1 (DCache-side prefetcher) request/return
   logic              d_rd_req;
   logic [1:0]        d_rd_type;
   logic [ADDR_W-1:0] d_rd_addr;
   logic              d_rd_rdy;
   logic              d_ret_valid;
   logic              d_ret_half;
   // shared return data
   logic [DATA_W-1:0] ret_data;
   // AXI read bridge side
   logic              axi_rd_req;
   logic [1:0]        axi_rd_type;
   logic [ADDR_W-1:0] axi_rd_addr;
   logic              axi_rd_rdy;
   logic              axi_ret_valid;
   logic              axi_ret_half;
   logic [DATA_W-1:0] axi_ret_data;

   // arbiter view
   modport slave (
      input  i_rd_req, i_rd_type, i_rd_addr,
      output i_rd_rdy, i_ret_valid, i_ret_half,
      input  d_rd_req, d_rd_type, d_rd_addr,
      output d_rd_rdy, d_ret_valid, d_ret_half,
      output ret_data,
      output axi_rd_req, axi_rd_type, axi_rd_addr,
      input  axi_rd_rdy, axi_ret_valid, axi_ret_half, axi_ret_data
   );

   // requester/bridge environment view
   modport master (
      output i_rd_req, i_rd_type, i_rd_addr,
      input  i_rd_rdy, i_ret_valid, i_ret_half,
      output d_rd_req, d_rd_type, d_rd_addr,
      input  d_rd_rdy, d_ret_valid, d_ret_half,
      input  ret_data,
      input  axi_rd_req, axi_rd_type, axi_rd_addr,
      output axi_rd_rdy, axi_ret_valid, axi_ret_half, axi_ret_data
   );
endinterface

// File: rtl/rd_port_arbiter.sv
// rtl/rd_port_arbiter.sv - round-robin arbiter sharing one AXI read port between ICache and prefetcher
module rd_port_arbiter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   rd_port_arbiter_if.slave bus,
   output logic [CNT_W-1:0] i_grant_cnt,
   output logic [CNT_W-1:0] d_grant_cnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q;
   logic             rr_pri_q;       // port favoured when both request
   logic             lock_q;         // grant frozen while the bridge stalls
   logic             locked_port_q;
   logic             owner_q;        // port that owns the outstanding transaction
   logic [CNT_W-1:0] i_cnt_q;
   logic [CNT_W-1:0] d_cnt_q;

   logic sel;
   logic sel_req;
   logic idle;
   logic busy;
   logic handshake;

   // pick the candidate port: a stalled grant stays put, otherwise sole requester or round-robin
   always_comb begin
      sel = rr_pri_q;
      if (lock_q)
         sel = locked_port_q;
      else if (bus.i_rd_req && !bus.d_rd_req)
         sel = 1'b0;
      else if (bus.d_rd_req && !bus.i_rd_req)
         sel = 1'b1;
   end

   assign idle      = (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign sel_req   = sel ? bus.d_rd_req : bus.i_rd_req;
   assign handshake = bus.axi_rd_req && bus.axi_rd_rdy;

   assign bus.axi_rd_req  = idle && sel_req;
   assign bus.axi_rd_type = sel ? bus.d_rd_type : bus.i_rd_type;
   assign bus.axi_rd_addr = sel ? bus.d_rd_addr : bus.i_rd_addr;

   assign bus.i_rd_rdy = handshake && !sel;
   assign bus.d_rd_rdy = handshake && sel;

   // return beats only reach the owner, and only while a transaction is outstanding
   assign bus.i_ret_valid = busy && !owner_q && bus.axi_ret_valid;
   assign bus.i_ret_half  = busy && !owner_q && bus.axi_ret_half;
   assign bus.d_ret_valid = busy && owner_q && bus.axi_ret_valid;
   assign bus.d_ret_half  = busy && owner_q && bus.axi_ret_half;
   assign bus.ret_data    = bus.axi_ret_data;

   assign i_grant_cnt = i_cnt_q;
   assign d_grant_cnt = d_cnt_q;

   // transaction FSM with grant lock, round-robin pointer and grant counters
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         rr_pri_q      <= 1'b1;
         lock_q        <= 1'b0;
         locked_port_q <= 1'b0;
         owner_q       <= 1'b0;
         i_cnt_q       <= '0;
         d_cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  state_q  <= BUSY;
                  owner_q  <= sel;
                  rr_pri_q <= ~sel;
                  lock_q   <= 1'b0;
                  if (sel)
                     d_cnt_q <= d_cnt_q + CNT_W'(1);
                  else
                     i_cnt_q <= i_cnt_q + CNT_W'(1);
               end else if (bus.axi_rd_req) begin
                  lock_q        <= 1'b1;
                  locked_port_q <= sel;
               end
            end
            BUSY: begin
               if (bus.axi_ret_valid)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// tb/tb_rd_port_arbiter.sv - directed self-checking bench for rd_port_arbiter
module tb_rd_port_arbiter;

   localparam logic [31:0]  A_I0 = 32'h1FC0_0000;
   localparam logic [31:0]  A_I1 = 32'h0000_1000;
   localparam logic [31:0]  A_D0 = 32'h0000_2000;
   localparam logic [31:0]  A_D1 = 32'h8000_0040;
   localparam logic [31:0]  A_D2 = 32'h8000_1000;
   localparam logic [255:0] DAT0 = {4{64'hA5A5_0123_4567_89AB}};
   localparam logic [255:0] DAT1 = {128'h0, 128'hDEAD_BEEF_CAFE_F00D_1122_3344_5566_7788};

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] i_grant_cnt;
   logic [31:0] d_grant_cnt;
   int          errors = 0;
   int          checks = 0;
   logic        exp_d;

   rd_port_arbiter_if bus ();

   rd_port_arbiter dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .i_grant_cnt (i_grant_cnt),
      .d_grant_cnt (d_grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // the bench must never drop a request whose grant is locked
   always @(negedge clk) begin
      if (resetn === 1'b1 && dut.lock_q === 1'b1) begin
         assert ((dut.locked_port_q ? bus.d_rd_req : bus.i_rd_req) === 1'b1)
         else begin
            errors++;
            $error("FAIL lock_drop observed=0 expected=1");
         end
      end
   end

   initial begin
      resetn = 1'b0;
      bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
      bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
      bus.axi_rd_rdy = 0; bus.axi_ret_valid = 0; bus.axi_ret_half = 0; bus.axi_ret_data = 0;
      repeat (2) step();
      settle();
      check("rst_axi_req", bus.axi_rd_req, 0);
      check("rst_i_rdy", bus.i_rd_rdy, 0);
      check("rst_d_rdy", bus.d_rd_rdy, 0);
      check("rst_i_ret", {bus.i_ret_valid, bus.i_ret_half}, 0);
      check("rst_d_ret", {bus.d_ret_valid, bus.d_ret_half}, 0);
      check("rst_i_cnt", i_grant_cnt, 0);
      check("rst_d_cnt", d_grant_cnt, 0);
      resetn = 1'b1;
      step();

      // single ICache line read
      bus.i_rd_req = 1; bus.i_rd_type = 2'b01; bus.i_rd_addr = A_I0; bus.axi_rd_rdy = 1;
      settle();
      check("t1_i_rdy", bus.i_rd_rdy, 1);
      check("t1_d_rdy", bus.d_rd_rdy, 0);
      check("t1_axi_req", bus.axi_rd_req, 1);
      check("t1_addr", bus.axi_rd_addr, A_I0);
      check("t1_type", bus.axi_rd_type, 2'b01);
      step();
      bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0; bus.axi_rd_rdy = 0;
      bus.axi_ret_half = 1; bus.axi_ret_valid = 1; bus.axi_ret_data = DAT0;
      settle();
      check("t1_i_cnt", i_grant_cnt, 1);
      check("t1_busy_no_req", bus.axi_rd_req, 0);
      check("t1_i_ret_valid", bus.i_ret_valid, 1);
      check("t1_i_ret_half", bus.i_ret_half, 1);
      check("t1_d_ret", {bus.d_ret_valid, bus.d_ret_half}, 0);
      check("t1_data", bus.ret_data, DAT0);
      step();
      bus.axi_ret_half = 0; bus.axi_ret_valid = 0;

      // round-robin alternation from reset, both ports always requesting
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      bus.i_rd_req = 1; bus.i_rd_type = 2'b01; bus.i_rd_addr = A_I1;
      bus.d_rd_req = 1; bus.d_rd_type = 2'b10; bus.d_rd_addr = A_D0;
      for (int k = 0; k < 6; k++) begin
         exp_d = (k % 2 == 0);
         bus.axi_rd_rdy = 1;
         settle();
         check("rr_addr", bus.axi_rd_addr, exp_d ? A_D0 : A_I1);
         check("rr_i_rdy", bus.i_rd_rdy, !exp_d);
         check("rr_d_rdy", bus.d_rd_rdy, exp_d);
         step();
         bus.axi_rd_rdy = 0; bus.axi_ret_valid = 1; bus.axi_ret_half = 1;
         settle();
         check("rr_busy_no_req", bus.axi_rd_req, 0);
         check("rr_i_ret", bus.i_ret_valid, !exp_d);
         check("rr_d_ret", bus.d_ret_valid, exp_d);
         step();
         bus.axi_ret_valid = 0; bus.axi_ret_half = 0;
      end
      bus.i_rd_req = 0; bus.i_rd_addr = 0; bus.i_rd_type = 0;
      bus.d_rd_req = 0; bus.d_rd_addr = 0; bus.d_rd_type = 0;
      settle();
      check("rr_i_cnt", i_grant_cnt, 3);
      check("rr_d_cnt", d_grant_cnt, 3);
      step();

      // port 1 two-line read: half at N, final at N+3
      bus.d_rd_req = 1; bus.d_rd_type = 2'b10; bus.d_rd_addr = A_D1; bus.axi_rd_rdy = 1;
      settle();
      check("t4_d_rdy", bus.d_rd_rdy, 1);
      step();
      bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0; bus.axi_rd_rdy = 0;
      settle();
      check("t4_d_cnt", d_grant_cnt, 4);
      step();
      bus.axi_ret_half = 1; bus.axi_ret_data = DAT1;
      settle();
      check("t4_N_d_half", bus.d_ret_half, 1);
      check("t4_N_d_valid", bus.d_ret_valid, 0);
      check("t4_N_i_half", bus.i_ret_half, 0);
      check("t4_N_data", bus.ret_data, DAT1);
      step();
      bus.axi_ret_half = 0;
      bus.d_rd_req = 1; bus.d_rd_type = 2'b10; bus.d_rd_addr = A_D2;
      settle();
      check("t4_N1_no_req", bus.axi_rd_req, 0);
      check("t4_N1_d_half", bus.d_ret_half, 0);
      step();
      settle();
      check("t4_N2_no_req", bus.axi_rd_req, 0);
      step();
      bus.axi_ret_valid = 1;
      settle();
      check("t4_N3_d_valid", bus.d_ret_valid, 1);
      check("t4_N3_i_valid", bus.i_ret_valid, 0);
      check("t4_N3_no_req", bus.axi_rd_req, 0);
      step();
      bus.axi_ret_valid = 0;

      // bridge stall: grant stays on port 1 although port 0 now has priority
      settle();
      check("t3_c1_req", bus.axi_rd_req, 1);
      check("t3_c1_addr", bus.axi_rd_addr, A_D2);
      check("t3_c1_d_rdy", bus.d_rd_rdy, 0);
      step();
      bus.i_rd_req = 1; bus.i_rd_type = 2'b01; bus.i_rd_addr = A_I1;
      for (int c = 2; c <= 4; c++) begin
         settle();
         check("t3_stall_addr", bus.axi_rd_addr, A_D2);
         check("t3_stall_type", bus.axi_rd_type, 2'b10);
         check("t3_stall_i_rdy", bus.i_rd_rdy, 0);
         step();
      end
      bus.axi_rd_rdy = 1;
      settle();
      check("t3_c5_d_rdy", bus.d_rd_rdy, 1);
      check("t3_c5_i_rdy", bus.i_rd_rdy, 0);
      step();
      bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0; bus.axi_rd_rdy = 0;
      settle();
      check("t3_d_cnt", d_grant_cnt, 5);
      bus.axi_ret_valid = 1;
      step();
      bus.axi_ret_valid = 0;
      bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;

      // return beat while idle is ignored
      bus.axi_ret_valid = 1; bus.axi_ret_half = 1;
      settle();
      check("t5_i_ret", {bus.i_ret_valid, bus.i_ret_half}, 0);
      check("t5_d_ret", {bus.d_ret_valid, bus.d_ret_half}, 0);
      step();
      bus.axi_ret_valid = 0; bus.axi_ret_half = 0;
      bus.i_rd_req = 1; bus.i_rd_type = 2'b00; bus.i_rd_addr = A_I0 + 32'h20; bus.axi_rd_rdy = 1;
      settle();
      check("t5_still_idle", bus.i_rd_rdy, 1);
      step();

      // reset while busy
      settle();
      check("t6_busy_i_rdy", bus.i_rd_rdy, 0);
      check("t6_i_cnt", i_grant_cnt, 4);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      settle();
      check("t6_i_cnt_clr", i_grant_cnt, 0);
      check("t6_d_cnt_clr", d_grant_cnt, 0);
      check("t6_i_rdy", bus.i_rd_rdy, 1);
      step();
      bus.i_rd_req = 0; bus.axi_rd_rdy = 0; bus.i_rd_addr = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rd_port_arbiter.md
Name: rd_port_arbiter

Overview:
- Shares the single AXI-bridge read port between the ICache requester (port 0) and the DCache-side prefetcher requester (port 1).
- Sits between both cache-side read interfaces and the AXI read bridge.
- Grants one transaction at a time, with round-robin priority and grant locking while the bridge stalls.
- Routes return beats only to the owning requester and tracks per-port grant counts.

Parameters:
ADDR_W, 32, read address width
DATA_W, 256, return data width (two 128-bit halves)
CNT_W, 32, width of per-port grant counters

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
i_rd_req  in  1  port 0 read request; held until i_rd_rdy
i_rd_type  in  2  port 0 type: 00 uncached word, 01 one line (128b), 10 two lines (256b)
i_rd_addr  in  ADDR_W  port 0 address
i_rd_rdy  out  1  port 0 request accepted this cycle
i_ret_valid  out  1  port 0 final return beat
i_ret_half  out  1  port 0 lower 128b valid early
d_rd_req  in  1  port 1 read request
d_rd_type  in  2  port 1 type
d_rd_addr  in  ADDR_W  port 1 address
d_rd_rdy  out  1  port 1 request accepted
d_ret_valid  out  1  port 1 final return beat
d_ret_half  out  1  port 1 lower half valid early
ret_data  out  DATA_W  return data, broadcast to both ports
axi_rd_req  out  1  request to bridge
axi_rd_type  out  2  muxed type
axi_rd_addr  out  ADDR_W  muxed address
axi_rd_rdy  in  1  bridge accepts
axi_ret_valid  in  1  bridge final beat
axi_ret_half  in  1  bridge lower-half early beat
axi_ret_data  in  DATA_W  bridge data
i_grant_cnt  out  CNT_W  accepted port 0 transactions
d_grant_cnt  out  CNT_W  accepted port 1 transactions

Behaviour:
- Reset: state IDLE; rr_pri=1 (port 1 favoured); lock=0; owner=0; counters=0.
- Reset outputs: axi_rd_req, all rdy, all ret_valid and ret_half = 0.
- States:
  - IDLE: no transaction outstanding; bridge request may be driven.
  - BUSY: one transaction outstanding; no new request driven.
- Selection in IDLE:
  - If lock=1, sel = locked_port.
  - Else if exactly one port requests, sel = that port.
  - Else if both request, sel = rr_pri.
- axi_rd_req = (state==IDLE) && sel port's req.
- axi_rd_type and axi_rd_addr are combinationally muxed from sel. Unselected fields are don't-care; the bench drives them as 0.
- Grant locking: if axi_rd_req=1 and axi_rd_rdy=0, set lock=1 and locked_port=sel. The grant must not switch until handshake, even if the other port has priority. Clear lock on handshake.
- Handshake: sel's rdy = (state==IDLE) && axi_rd_req && axi_rd_rdy. Combinational, same cycle. Non-selected rdy = 0.
- On handshake:
  - owner <= sel; state <= BUSY.
  - rr_pri <= ~sel.
  - Increment sel's grant counter. Counters wrap modulo 2^CNT_W.
- In BUSY:
  - owner's ret_half = axi_ret_half; owner's ret_valid = axi_ret_valid.
  - Other port's ret signals are 0.
  - ret_data = axi_ret_data always.
  - Both rdy = 0.
- BUSY -> IDLE on axi_ret_valid. A new request may be driven in the cycle after axi_ret_valid: one bubble minimum.
- ret_half and ret_valid may coincide (uncached or single line); pass both through unchanged.
- Return beats while IDLE are ignored: no ret signal asserts.
- A requester dropping req while not granted has no effect. Dropping req while locked is a protocol violation; the bench asserts it never happens.
- Reset mid-transaction returns to IDLE immediately. Late bridge returns are dropped.

Test Plan:
- Only i_rd_req, type 01, addr 0x1FC00000, axi_rd_rdy=1 -> same-cycle i_rd_rdy=1, axi_rd_addr=0x1FC00000; then axi_ret_half+axi_ret_valid -> i_ret_valid=1, d_ret_valid=0; i_grant_cnt=1.
- Both requesting after reset, rdy=1 -> port 1 granted first. Next grant (after return) goes to port 0. Then port 1 again: alternation verified over 6 transactions, counters 3/3.
- d_rd_req type 10, axi_rd_rdy=0 for 4 cycles while i_rd_req rises and rr_pri favours port 0 -> axi_rd_addr stays d_rd_addr all 4 cycles; d_rd_rdy on cycle 5.
- Port 1 type 10: axi_ret_half cycle N, axi_ret_valid cycle N+3 -> d_ret_half=1 at N, d_ret_valid=1 at N+3, i_ret_* stay 0; new axi_rd_req no earlier than N+4.
- axi_ret_valid pulsed in IDLE -> no ret_valid on either port; state stays IDLE.
- resetn low for 1 cycle while BUSY -> next cycle state IDLE, counters 0, a pending i_rd_req is accepted immediately with rdy=1.
